// File: rtl/ext_mem_responder_pkg.sv
// Shared types and constants for the external memory responder and its RAM.
package ext_mem_pkg;

    localparam int EXT_ADDR_W = 24;
    localparam int EXT_DATA_W = 16;
    localparam int EXT_MASK_W = 2;

    localparam logic EXT_OP_READ  = 1'b0;
    localparam logic EXT_OP_WRITE = 1'b1;

    // Lane mask bits: a set bit suppresses the write of that byte lane.
    localparam int MASK_LO_BIT = 0;
    localparam int MASK_HI_BIT = 1;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_RECOV
    } state_t;

    function automatic logic [3:0] last_count(input int cycles);
        return 4'(cycles - 1);
    endfunction

endpackage

// File: rtl/ext_mem_responder_if.sv
// External memory request bus between the memory adapter (master) and the responder (slave).
interface ext_mem_responder_if;
    import ext_mem_pkg::*;

    logic [EXT_ADDR_W-1:0] ExtAddr;
    logic [EXT_DATA_W-1:0] ExtDataWrite;
    logic [EXT_MASK_W-1:0] ExtDataMask;
    logic                  ExtOP;
    logic                  ExtReq;
    logic                  ExtReady;
    logic [EXT_DATA_W-1:0] ExtDataRead;

    modport master (
        output ExtAddr, ExtDataWrite, ExtDataMask, ExtOP, ExtReq,
        input  ExtReady, ExtDataRead
    );

    modport slave (
        input  ExtAddr, ExtDataWrite, ExtDataMask, ExtOP, ExtReq,
        output ExtReady, ExtDataRead
    );

endinterface

// File: rtl/ext_mem_responder_spram.sv
// Single-port 16-bit synchronous RAM with active-low byte write enables and 1-cycle read latency.
module ext_mem_spram
    import ext_mem_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [EXT_MASK_W-1:0] we_n,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [EXT_DATA_W-1:0] wdata,
    output logic [EXT_DATA_W-1:0] rdata
);

    logic [EXT_DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    // Array has no reset so contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (!we_n[MASK_LO_BIT]) begin
                mem[addr][7:0] <= wdata[7:0];
            end
            if (!we_n[MASK_HI_BIT]) begin
                mem[addr][15:8] <= wdata[15:8];
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ext_mem_responder.sv
// Responder for the 16-bit external memory bus backed by on-chip RAM with wait states.
// Optional EXT_REQ_EDGE_EN: a held ExtReq yields one transaction instead of repeating.
module ext_mem_responder
    import ext_mem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 12,
    parameter int WAIT_STATES = 2,
    parameter int RECOVERY    = 1
) (
    input  logic              PixelClk2,
    input  logic              nReset,
    ext_mem_responder_if.slave ext
);

    localparam logic [3:0] WAIT_LAST  = last_count(WAIT_STATES);
    localparam logic [3:0] RECOV_LAST = last_count(RECOVERY);

    state_t                state, state_next;
    logic [3:0]            cnt, cnt_next;
    logic                  ready_q, ready_next;
    logic [EXT_DATA_W-1:0] data_q, data_next;
    logic [DEPTH_LOG2-1:0] addr_q, addr_next;
    logic [EXT_DATA_W-1:0] wdata_q, wdata_next;
    logic [EXT_MASK_W-1:0] mask_q, mask_next;
    logic                  op_q, op_next;
`ifdef EXT_REQ_EDGE_EN
    logic                  armed, armed_next;
`endif

    logic                  accept;
    logic                  commit;
    logic                  ram_en;
    logic [EXT_MASK_W-1:0] ram_we_n;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [EXT_DATA_W-1:0] ram_rdata;

    logic unused_addr_hi;
    assign unused_addr_hi = ^ext.ExtAddr[EXT_ADDR_W-1:DEPTH_LOG2];

    // Upper address bits are dropped, so addresses alias modulo the RAM depth.
    always_comb begin
        accept = (state == ST_IDLE) && ready_q && ext.ExtReq;
`ifdef EXT_REQ_EDGE_EN
        accept = accept && armed;
`endif
        commit   = (state == ST_WAIT) && (cnt == WAIT_LAST);
        ram_addr = (state == ST_IDLE) ? ext.ExtAddr[DEPTH_LOG2-1:0] : addr_q;
        ram_en   = accept || (commit && (op_q == EXT_OP_WRITE));
        ram_we_n = (commit && (op_q == EXT_OP_WRITE)) ? mask_q : '1;
    end

    ext_mem_spram #(
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk   (PixelClk2),
        .en    (ram_en),
        .we_n  (ram_we_n),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ready_next = ready_q;
        data_next  = data_q;
        addr_next  = addr_q;
        wdata_next = wdata_q;
        mask_next  = mask_q;
        op_next    = op_q;
`ifdef EXT_REQ_EDGE_EN
        armed_next = armed;
        if (!ext.ExtReq) begin
            armed_next = 1'b1;
        end
        if (accept) begin
            armed_next = 1'b0;
        end
`endif

        case (state)
            ST_INIT: begin
                state_next = ST_IDLE;
                ready_next = 1'b1;
            end
            ST_IDLE: begin
                if (accept) begin
                    addr_next  = ext.ExtAddr[DEPTH_LOG2-1:0];
                    wdata_next = ext.ExtDataWrite;
                    mask_next  = ext.ExtDataMask;
                    op_next    = ext.ExtOP;
                    cnt_next   = '0;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    state_next = ST_DONE;
                    ready_next = 1'b0;
                    cnt_next   = '0;
                    if (op_q == EXT_OP_READ) begin
                        data_next = ram_rdata;
                    end
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            ST_DONE, ST_RECOV: begin
                if (cnt == RECOV_LAST) begin
                    state_next = ST_IDLE;
                    ready_next = 1'b1;
                end else begin
                    cnt_next   = cnt + 4'd1;
                    state_next = ST_RECOV;
                end
            end
            default: begin
                state_next = ST_INIT;
                ready_next = 1'b0;
            end
        endcase
    end

    // A write only reaches the RAM at completion, so reset before that discards it.
    always_ff @(posedge PixelClk2 or negedge nReset) begin
        if (!nReset) begin
            state   <= ST_INIT;
            cnt     <= '0;
            ready_q <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            op_q    <= EXT_OP_READ;
`ifdef EXT_REQ_EDGE_EN
            armed   <= 1'b1;
`endif
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            ready_q <= ready_next;
            data_q  <= data_next;
            addr_q  <= addr_next;
            wdata_q <= wdata_next;
            mask_q  <= mask_next;
            op_q    <= op_next;
`ifdef EXT_REQ_EDGE_EN
            armed   <= armed_next;
`endif
        end
    end

    assign ext.ExtReady    = ready_q;
    assign ext.ExtDataRead = data_q;

endmodule
